// File: rtl/cpu_pkg.sv
// Shared types and constants for the cpu_pipeline_core 5-stage RV32I-subset pipeline.
package cpu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned NREGS  = 32;

  localparam logic [XLEN-1:0] NOP = 32'h00000013;

  // Major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // funct3 encodings
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  // funct7 encodings
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_PASS_B
  } alu_op_e;

  // EX operand source chosen at decode time
  typedef enum logic [1:0] {FWD_NONE, FWD_EXMEM, FWD_MEMWB} fwd_sel_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } ifid_t;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    alu_op_e           alu_op;
    logic              use_imm;
    logic              reg_write;
    logic              is_branch;
    logic              br_ne;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic [XLEN-1:0]   imm;
    fwd_sel_e          fwd_a;
    fwd_sel_e          fwd_b;
  } idex_t;

  // Shared by EX/MEM and MEM/WB: no data memory, so MEM only carries the result
  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   result;
  } exwb_t;

  // Map funct3 (plus the alternate-encoding bit) onto an ALU operation
  function automatic alu_op_e f3_to_op(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD_SUB: return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     return ALU_SLL;
      F3_SLT:     return ALU_SLT;
      F3_SLTU:    return ALU_SLTU;
      F3_XOR:     return ALU_XOR;
      F3_SRL_SRA: return alt ? ALU_SRA : ALU_SRL;
      F3_OR:      return ALU_OR;
      default:    return ALU_AND;
    endcase
  endfunction

  // 32-bit wrap-around ALU; shift amount taken from b[4:0]
  function automatic logic [XLEN-1:0] alu(input alu_op_e op, input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      ALU_ADD:    return a + b;
      ALU_SUB:    return a - b;
      ALU_AND:    return a & b;
      ALU_OR:     return a | b;
      ALU_XOR:    return a ^ b;
      ALU_SLL:    return a << sh;
      ALU_SRL:    return a >> sh;
      ALU_SRA:    return XLEN'($signed(a) >>> sh);
      ALU_SLT:    return {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU:   return {31'b0, a < b};
      ALU_PASS_B: return b;
      default:    return '0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 32x32 register file: 2 combinational read ports with write-through bypass, 1 write port.
module cpu_regfile
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [XLEN-1:0]   rdata1_c,
  output logic [XLEN-1:0]   rdata2_c,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   dbg_x1_c,
  output logic [XLEN-1:0]   dbg_x2_c,
  output logic [XLEN-1:0]   dbg_x3_c
);

  logic [XLEN-1:0] registers [NREGS];

  // Architectural state; x0 is never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) registers[i] <= '0;
    end else if (we && (waddr != '0)) begin
      registers[waddr] <= wdata;
    end
  end

  // Read ports: x0 reads zero, a same-cycle write is passed straight through
  always_comb begin
    rdata1_c = '0;
    rdata2_c = '0;
    if (raddr1 != '0) rdata1_c = (we && (waddr == raddr1)) ? wdata : registers[raddr1];
    if (raddr2 != '0) rdata2_c = (we && (waddr == raddr2)) ? wdata : registers[raddr2];
  end

  assign dbg_x1_c = registers[1];
  assign dbg_x2_c = registers[2];
  assign dbg_x3_c = registers[3];

endmodule

// File: rtl/cpu_pipeline_core.sv
// 5-stage in-order RV32I-subset core (IF/ID/EX/MEM/WB) with internal IMEM and regfile.
// Build option CPU_FWD_EN: EX operand forwarding; when undefined, an ID interlock
// stalls dependent instructions instead.
module cpu_pipeline_core
  import cpu_pkg::*;
#(
  parameter int unsigned     IMEM_DEPTH = 256,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h00000000
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] pc_current,
  output logic [XLEN-1:0] instruction_debug,
  output logic [3:0]      pipeline_state,
  output logic [XLEN-1:0] debug_reg1,
  output logic [XLEN-1:0] debug_reg2,
  output logic [XLEN-1:0] debug_reg3
);

  localparam int unsigned IMEM_AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

  logic [XLEN-1:0] pc_q, pc_d;
  ifid_t           ifid_q, ifid_d;
  idex_t           idex_q, idex_d, id_dec;
  exwb_t           exmem_q, exmem_d, memwb_q;
  logic [XLEN-1:0] fetch_word_c;
  logic            stall_c;
  logic            br_taken_c;
  logic [XLEN-1:0] br_target_c;
  logic [XLEN-1:0] rf_rdata1, rf_rdata2;

  // Instruction memory, preloaded by benches through the hierarchy
  if (1'b1) begin : imem
    logic [XLEN-1:0] imem [IMEM_DEPTH];
  end

  // Fetch: combinational read, NOP outside the populated range
  always_comb begin
    fetch_word_c = NOP;
    if ({2'b00, pc_q[XLEN-1:2]} < IMEM_DEPTH) fetch_word_c = imem.imem[pc_q[IMEM_AW+1:2]];
  end

  logic [6:0]        id_opc;
  logic [2:0]        id_f3;
  logic [6:0]        id_f7;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic [XLEN-1:0]   imm_i, imm_b, imm_u;

  assign id_opc = ifid_q.instr[6:0];
  assign id_rd  = ifid_q.instr[11:7];
  assign id_f3  = ifid_q.instr[14:12];
  assign id_rs1 = ifid_q.instr[19:15];
  assign id_rs2 = ifid_q.instr[24:20];
  assign id_f7  = ifid_q.instr[31:25];
  assign imm_i  = {{20{ifid_q.instr[31]}}, ifid_q.instr[31:20]};
  assign imm_b  = {{19{ifid_q.instr[31]}}, ifid_q.instr[31], ifid_q.instr[7],
                   ifid_q.instr[30:25], ifid_q.instr[11:8], 1'b0};
  assign imm_u  = {ifid_q.instr[31:12], 12'b0};

  cpu_regfile register_file (
    .clk      (clk),
    .rst_n    (reset),
    .raddr1   (id_rs1),
    .raddr2   (id_rs2),
    .rdata1_c (rf_rdata1),
    .rdata2_c (rf_rdata2),
    .we       (memwb_q.valid && memwb_q.reg_write),
    .waddr    (memwb_q.rd),
    .wdata    (memwb_q.result),
    .dbg_x1_c (debug_reg1),
    .dbg_x2_c (debug_reg2),
    .dbg_x3_c (debug_reg3)
  );

  // Decode: unsupported encodings fall through as NOPs (no write, no redirect)
  always_comb begin
    id_dec           = '0;
    id_dec.valid     = ifid_q.valid;
    id_dec.pc        = ifid_q.pc;
    id_dec.rd        = id_rd;
    id_dec.rs1_val   = rf_rdata1;
    id_dec.rs2_val   = rf_rdata2;
    id_dec.imm       = imm_i;
    id_dec.alu_op    = ALU_ADD;
    id_dec.fwd_a     = FWD_NONE;
    id_dec.fwd_b     = FWD_NONE;
    case (id_opc)
      OPC_OP: begin
        id_dec.alu_op    = f3_to_op(id_f3, id_f7 == F7_ALT);
        id_dec.reg_write = ifid_q.valid && ((id_f7 == F7_BASE) ||
                           ((id_f7 == F7_ALT) && ((id_f3 == F3_ADD_SUB) || (id_f3 == F3_SRL_SRA))));
      end
      OPC_OP_IMM: begin
        id_dec.use_imm = 1'b1;
        id_dec.alu_op  = f3_to_op(id_f3, (id_f3 == F3_SRL_SRA) && (id_f7 == F7_ALT));
        if ((id_f3 == F3_SLL) || (id_f3 == F3_SRL_SRA))
          id_dec.reg_write = ifid_q.valid && ((id_f7 == F7_BASE) ||
                             ((id_f7 == F7_ALT) && (id_f3 == F3_SRL_SRA)));
        else
          id_dec.reg_write = ifid_q.valid;
      end
      OPC_LUI: begin
        id_dec.use_imm   = 1'b1;
        id_dec.imm       = imm_u;
        id_dec.alu_op    = ALU_PASS_B;
        id_dec.reg_write = ifid_q.valid;
      end
      OPC_BRANCH: begin
        id_dec.imm       = imm_b;
        id_dec.is_branch = ifid_q.valid && ((id_f3 == F3_BEQ) || (id_f3 == F3_BNE));
        id_dec.br_ne     = (id_f3 == F3_BNE);
      end
      default: ;
    endcase
`ifdef CPU_FWD_EN
    // Next cycle ID/EX sits in EX/MEM and EX/MEM in MEM/WB; nearest producer wins
    if (idex_q.valid && idex_q.reg_write && (idex_q.rd != '0) && (idex_q.rd == id_rs1))
      id_dec.fwd_a = FWD_EXMEM;
    else if (exmem_q.valid && exmem_q.reg_write && (exmem_q.rd != '0) && (exmem_q.rd == id_rs1))
      id_dec.fwd_a = FWD_MEMWB;
    if (idex_q.valid && idex_q.reg_write && (idex_q.rd != '0) && (idex_q.rd == id_rs2))
      id_dec.fwd_b = FWD_EXMEM;
    else if (exmem_q.valid && exmem_q.reg_write && (exmem_q.rd != '0) && (exmem_q.rd == id_rs2))
      id_dec.fwd_b = FWD_MEMWB;
`endif
  end

`ifdef CPU_FWD_EN
  assign stall_c = 1'b0;
`else
  // Interlock: hold ID until producers in EX and MEM have reached WB (regfile bypass covers WB)
  always_comb begin
    stall_c = 1'b0;
    if (ifid_q.valid) begin
      if (idex_q.valid && idex_q.reg_write && (idex_q.rd != '0) &&
          ((idex_q.rd == id_rs1) || (idex_q.rd == id_rs2)))
        stall_c = 1'b1;
      if (exmem_q.valid && exmem_q.reg_write && (exmem_q.rd != '0) &&
          ((exmem_q.rd == id_rs1) || (exmem_q.rd == id_rs2)))
        stall_c = 1'b1;
    end
  end
`endif

  logic [XLEN-1:0] ex_a, ex_b_reg, ex_b;

  // Execute: operand select, ALU and branch resolution
  always_comb begin
    case (idex_q.fwd_a)
      FWD_EXMEM: ex_a = exmem_q.result;
      FWD_MEMWB: ex_a = memwb_q.result;
      default:   ex_a = idex_q.rs1_val;
    endcase
    case (idex_q.fwd_b)
      FWD_EXMEM: ex_b_reg = exmem_q.result;
      FWD_MEMWB: ex_b_reg = memwb_q.result;
      default:   ex_b_reg = idex_q.rs2_val;
    endcase
    ex_b              = idex_q.use_imm ? idex_q.imm : ex_b_reg;
    exmem_d.valid     = idex_q.valid;
    exmem_d.reg_write = idex_q.valid && idex_q.reg_write;
    exmem_d.rd        = idex_q.rd;
    exmem_d.result    = alu(idex_q.alu_op, ex_a, ex_b);
    br_taken_c        = idex_q.valid && idex_q.is_branch && ((ex_a == ex_b_reg) ^ idex_q.br_ne);
    br_target_c       = idex_q.pc + idex_q.imm;
  end

  // Front-end next state: redirect beats stall
  always_comb begin
    pc_d   = pc_q + 32'd4;
    ifid_d = '{valid: 1'b1, pc: pc_q, instr: fetch_word_c};
    idex_d = id_dec;
    if (br_taken_c) begin
      pc_d   = br_target_c;
      ifid_d = '{valid: 1'b0, pc: pc_q, instr: NOP};
      idex_d = '0;
    end else if (stall_c) begin
      pc_d   = pc_q;
      ifid_d = ifid_q;
      idex_d = '0;
    end
  end

  // Pipeline registers; reset discards everything in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      ifid_q  <= '0;
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= exmem_q;
    end
  end

  assign pc_current        = pc_q;
  assign instruction_debug = ifid_q.instr;
  assign pipeline_state    = {memwb_q.valid, exmem_q.valid, idex_q.valid, ifid_q.valid};

endmodule

// File: tb/tb_cpu_pipeline_core.sv
// Self-checking bench for cpu_pipeline_core: directed programs plus random programs
// checked against an instruction-level interpreter.
module tb_cpu_pipeline_core;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] NOP_W = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc_current, instruction_debug, debug_reg1, debug_reg2, debug_reg3;
  logic [3:0]  pipeline_state;

  cpu_pipeline_core #(.IMEM_DEPTH(DEPTH), .RESET_PC(32'h00000000)) dut (
    .clk               (clk),
    .reset             (reset),
    .pc_current        (pc_current),
    .instruction_debug (instruction_debug),
    .pipeline_state    (pipeline_state),
    .debug_reg1        (debug_reg1),
    .debug_reg2        (debug_reg2),
    .debug_reg3        (debug_reg3)
  );

  always #5 clk = ~clk;

  typedef enum int {
    T_ADD, T_SUB, T_AND, T_OR, T_XOR, T_SLL, T_SRL, T_SRA, T_SLT, T_SLTU,
    T_ADDI, T_ANDI, T_ORI, T_XORI, T_SLTI, T_SLTIU, T_SLLI, T_SRLI, T_SRAI,
    T_LUI, T_BEQ, T_BNE, T_BAD
  } kind_e;

  typedef struct {
    kind_e      k;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    int         imm;
  } ins_t;

  int          errors = 0;
  int          checks = 0;
  ins_t        prog[$];
  logic [31:0] words[$];
  logic [31:0] mregs[32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic ins_t mk(input kind_e k, input int rd, input int rs1, input int rs2,
                              input int imm);
    ins_t x;
    x.k = k; x.rd = 5'(rd); x.rs1 = 5'(rs1); x.rs2 = 5'(rs2); x.imm = imm;
    return x;
  endfunction

  // Instruction word assembler
  function automatic logic [31:0] encode(input ins_t x);
    logic [11:0] i12;
    logic [12:0] b13;
    logic [19:0] u20;
    i12 = 12'(x.imm);
    b13 = 13'(x.imm);
    u20 = 20'(x.imm);
    case (x.k)
      T_ADD:   return {7'h00, x.rs2, x.rs1, 3'b000, x.rd, 7'h33};
      T_SUB:   return {7'h20, x.rs2, x.rs1, 3'b000, x.rd, 7'h33};
      T_SLL:   return {7'h00, x.rs2, x.rs1, 3'b001, x.rd, 7'h33};
      T_SLT:   return {7'h00, x.rs2, x.rs1, 3'b010, x.rd, 7'h33};
      T_SLTU:  return {7'h00, x.rs2, x.rs1, 3'b011, x.rd, 7'h33};
      T_XOR:   return {7'h00, x.rs2, x.rs1, 3'b100, x.rd, 7'h33};
      T_SRL:   return {7'h00, x.rs2, x.rs1, 3'b101, x.rd, 7'h33};
      T_SRA:   return {7'h20, x.rs2, x.rs1, 3'b101, x.rd, 7'h33};
      T_OR:    return {7'h00, x.rs2, x.rs1, 3'b110, x.rd, 7'h33};
      T_AND:   return {7'h00, x.rs2, x.rs1, 3'b111, x.rd, 7'h33};
      T_ADDI:  return {i12, x.rs1, 3'b000, x.rd, 7'h13};
      T_SLTI:  return {i12, x.rs1, 3'b010, x.rd, 7'h13};
      T_SLTIU: return {i12, x.rs1, 3'b011, x.rd, 7'h13};
      T_XORI:  return {i12, x.rs1, 3'b100, x.rd, 7'h13};
      T_ORI:   return {i12, x.rs1, 3'b110, x.rd, 7'h13};
      T_ANDI:  return {i12, x.rs1, 3'b111, x.rd, 7'h13};
      T_SLLI:  return {7'h00, i12[4:0], x.rs1, 3'b001, x.rd, 7'h13};
      T_SRLI:  return {7'h00, i12[4:0], x.rs1, 3'b101, x.rd, 7'h13};
      T_SRAI:  return {7'h20, i12[4:0], x.rs1, 3'b101, x.rd, 7'h13};
      T_LUI:   return {u20, x.rd, 7'h37};
      T_BEQ:   return {b13[12], b13[10:5], x.rs2, x.rs1, 3'b000, b13[4:1], b13[11], 7'h63};
      T_BNE:   return {b13[12], b13[10:5], x.rs2, x.rs1, 3'b001, b13[4:1], b13[11], 7'h63};
      default: return {i12, x.rs1, 3'b010, x.rd, 7'h03};  // load opcode, executes as NOP
    endcase
  endfunction

  // Sequential ISA interpreter: one instruction at a time, no pipeline notion
  task automatic model_run();
    int          idx, steps;
    ins_t        x;
    logic [31:0] a, b, im, r;
    bit          wr;
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    idx = 0;
    steps = 0;
    while (idx < prog.size() && steps < 1000) begin
      x = prog[idx];
      a = mregs[x.rs1];
      b = mregs[x.rs2];
      im = 32'(x.imm);
      r = '0;
      wr = 1'b1;
      idx++;
      steps++;
      case (x.k)
        T_ADD:   r = a + b;
        T_SUB:   r = a - b;
        T_AND:   r = a & b;
        T_OR:    r = a | b;
        T_XOR:   r = a ^ b;
        T_SLL:   r = a << b[4:0];
        T_SRL:   r = a >> b[4:0];
        T_SRA:   r = 32'($signed(a) >>> b[4:0]);
        T_SLT:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        T_SLTU:  r = (a < b) ? 32'd1 : 32'd0;
        T_ADDI:  r = a + im;
        T_ANDI:  r = a & im;
        T_ORI:   r = a | im;
        T_XORI:  r = a ^ im;
        T_SLTI:  r = ($signed(a) < $signed(im)) ? 32'd1 : 32'd0;
        T_SLTIU: r = (a < im) ? 32'd1 : 32'd0;
        T_SLLI:  r = a << im[4:0];
        T_SRLI:  r = a >> im[4:0];
        T_SRAI:  r = 32'($signed(a) >>> im[4:0]);
        T_LUI:   r = im << 12;
        T_BEQ:   begin wr = 1'b0; if (a == b) idx = idx - 1 + x.imm / 4; end
        T_BNE:   begin wr = 1'b0; if (a != b) idx = idx - 1 + x.imm / 4; end
        default: wr = 1'b0;
      endcase
      if (wr && x.rd != 5'd0) mregs[x.rd] = r;
    end
  endtask

  task automatic gen_prog(input int len);
    ins_t x;
    int   off;
    prog.delete();
    for (int i = 0; i < len; i++) begin
      x.k = kind_e'($urandom_range(0, int'(T_BAD)));
      if ($urandom_range(0, 2) == 0) x.k = ($urandom_range(0, 1) == 1) ? T_LUI : T_ADDI;
      x.rd  = 5'($urandom_range(0, 7));
      x.rs1 = 5'($urandom_range(0, 7));
      x.rs2 = 5'($urandom_range(0, 7));
      case (x.k)
        T_SLLI, T_SRLI, T_SRAI: x.imm = int'($urandom_range(0, 31));
        T_LUI: x.imm = int'($urandom_range(0, 32'hFFFFF));
        T_BEQ, T_BNE: begin
          off = 4 * int'($urandom_range(1, 4));
          if (off > 4 * (len - i)) off = 4 * (len - i);
          x.imm = off;
        end
        default: x.imm = int'($urandom_range(0, 4095)) - 2048;
      endcase
      prog.push_back(x);
    end
  endtask

  task automatic words_from_prog();
    words.delete();
    foreach (prog[i]) words.push_back(encode(prog[i]));
  endtask

  // Hold reset two cycles while loading IMEM, release on a falling edge
  task automatic start_prog();
    reset = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) dut.imem.imem[i] = NOP_W;
    foreach (words[i]) dut.imem.imem[i] = words[i];
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_x123(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                            input logic [31:0] e3);
    check({tag, "_x1"}, dut.register_file.registers[1], e1);
    check({tag, "_x2"}, dut.register_file.registers[2], e2);
    check({tag, "_x3"}, dut.register_file.registers[3], e3);
  endtask

  initial begin
    // Test 1: basic add program, reset state and first fetch
    words = '{32'h00A00093, 32'h00500113, 32'h002081B3, NOP_W, NOP_W, NOP_W};
    start_prog();
    check("rst_pc", pc_current, 32'h0);
    check("rst_state", 32'(pipeline_state), 32'h0);
    check("rst_instr", instruction_debug, 32'h0);
    check("rst_dbg1", debug_reg1, 32'h0);
    check("rst_dbg2", debug_reg2, 32'h0);
    check("rst_dbg3", debug_reg3, 32'h0);
    run_cycles(1);
    check("fetch1_state", 32'(pipeline_state), 32'h1);
    check("fetch1_pc", pc_current, 32'h4);
    check("fetch1_instr", instruction_debug, 32'h00A00093);
    run_cycles(14);
    check_x123("t1", 32'hA, 32'h5, 32'hF);
    check("t1_dbg1", debug_reg1, 32'hA);
    check("t1_dbg2", debug_reg2, 32'h5);
    check("t1_dbg3", debug_reg3, 32'hF);

    // Test 6: asynchronous reset mid-run, observed before any clock edge
    #2 reset = 1'b0;
    #1;
    check("arst_pc", pc_current, 32'h0);
    check("arst_state", 32'(pipeline_state), 32'h0);
    check("arst_dbg1", debug_reg1, 32'h0);
    check("arst_dbg2", debug_reg2, 32'h0);
    check("arst_dbg3", debug_reg3, 32'h0);

    // Test 2: negative immediate, SUB, signed compare
    prog = '{mk(T_ADDI, 1, 0, 0, -1), mk(T_SUB, 2, 0, 1, 0), mk(T_SLT, 3, 1, 0, 0)};
    words_from_prog(); start_prog(); run_cycles(40);
    check_x123("t2", 32'hFFFFFFFF, 32'h1, 32'h1);

    // Test 3: taken branch flushes the shadow instruction
    prog = '{mk(T_ADDI, 1, 0, 0, 3), mk(T_BEQ, 0, 0, 0, 8), mk(T_ADDI, 2, 0, 0, 7),
             mk(T_ADDI, 3, 0, 0, 9)};
    words_from_prog(); start_prog(); run_cycles(40);
    check_x123("t3", 32'h3, 32'h0, 32'h9);

    // Test 4: x0 is hardwired to zero
    prog = '{mk(T_ADDI, 0, 0, 0, 5), mk(T_ADD, 1, 0, 0, 0)};
    words_from_prog(); start_prog(); run_cycles(40);
    check("t4_x0", dut.register_file.registers[0], 32'h0);
    check("t4_x1", dut.register_file.registers[1], 32'h0);

    // Test 5: LUI followed by dependent ADDI
    prog = '{mk(T_LUI, 1, 0, 0, 32'h12345), mk(T_ADDI, 1, 1, 0, 32'h678)};
    words_from_prog(); start_prog(); run_cycles(40);
    check("t5_x1", dut.register_file.registers[1], 32'h12345678);

    // Unimplemented opcode and not-taken BNE leave state untouched
    prog = '{mk(T_ADDI, 1, 0, 0, 5), mk(T_BAD, 1, 0, 0, 0), mk(T_BNE, 0, 1, 1, 8),
             mk(T_ADDI, 2, 1, 0, 1), mk(T_ADDI, 3, 2, 0, 1)};
    words_from_prog(); start_prog(); run_cycles(40);
    check_x123("nop", 32'h5, 32'h6, 32'h7);

    // Random programs with dense register reuse
    for (int n = 0; n < 8; n++) begin
      gen_prog(24);
      model_run();
      words_from_prog();
      start_prog();
      run_cycles(110);
      for (int r = 0; r < 32; r++)
        check($sformatf("rand%0d_x%0d", n, r), dut.register_file.registers[r], mregs[r]);
      check($sformatf("rand%0d_dbg1", n), debug_reg1, mregs[1]);
      check($sformatf("rand%0d_dbg2", n), debug_reg2, mregs[2]);
      check($sformatf("rand%0d_dbg3", n), debug_reg3, mregs[3]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
